// File: rtl/count100_pkg.sv
// ---------------------------------------------------------------------------
// count100_pkg
// Shared constants and types for the modulo-N timebase counter and its
// BCD digit sub-counters.
// ---------------------------------------------------------------------------
package count100_pkg;

    // Default counter modulus and binary width (100 states fit in 8 bits).
    localparam int unsigned DEFAULT_MODULUS = 100;
    localparam int unsigned DEFAULT_WIDTH   = 8;

    // One BCD digit.
    localparam int unsigned BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Largest legal digit value.
    localparam bcd_digit_t BCD_MAX = BCD_W'(9);

    // True when a digit register holds a non-decimal code (e.g. after an upset).
    function automatic logic bcd_illegal(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage : count100_pkg

// File: rtl/count100_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// count100_bcd_digit_counter
// One decimal digit (0..9) with carry-in and carry-out. Two of these are
// chained to form the tens/ones view of the binary count.
//
// Ports:
//   clk     input   rising-edge clock
//   rst_n   input   asynchronous active-low reset, clears the digit
//   cin     input   advance the digit on this edge
//   clr     input   synchronous clear, wins over cin
//   digit   output  registered digit value
//   cout_c  output  combinational carry: cin while the digit is at 9
// ---------------------------------------------------------------------------
module count100_bcd_digit_counter
    import count100_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cin,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       cout_c
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Next digit: clear / illegal-code recovery first, then the decimal wrap.
    always_comb begin
        digit_d = digit_q;
        if (clr || bcd_illegal(digit_q)) begin
            digit_d = '0;
        end else if (cin) begin
            if (digit_q == BCD_MAX) begin
                digit_d = '0;
            end else begin
                digit_d = digit_q + BCD_W'(1);
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign cout_c = cin && (digit_q == BCD_MAX);

endmodule : count100_bcd_digit_counter

// File: rtl/count100.sv
// ---------------------------------------------------------------------------
// count100
// Free-running modulo-MODULUS up-counter used as a frame/line sequencing
// timebase. Provides the binary count, a registered BCD (tens/ones) view of
// the same value, and a terminal-count decode.
//
// Ports:
//   clk         input   rising-edge clock
//   reset       input   asynchronous active-low reset (0 = in reset)
//   count       output  binary count, 0..MODULUS-1 (registered)
//   count_tens  output  BCD tens digit (registered)
//   count_ones  output  BCD ones digit (registered)
//   tc          output  terminal count, high while count == MODULUS-1
//                       (combinational decode of the count register)
//
// MODULUS must be in 2..100 so the BCD view fits two digits, and
// 2**WIDTH >= MODULUS.
// ---------------------------------------------------------------------------
module count100
    import count100_pkg::*;
#(
    parameter int unsigned MODULUS = DEFAULT_MODULUS,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output bcd_digit_t       count_tens,
    output bcd_digit_t       count_ones,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_c;
    logic             ones_cout_c;
    logic             unused_tens_cout;

    // Wrap on the terminal value, and also on any out-of-range value so an
    // upset count self-recovers to 0 on the next edge with the digits.
    assign wrap_c = (count_q >= LAST);

    // Binary next-count.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (wrap_c) begin
            count_d = '0;
        end
    end

    // Binary count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Ones digit advances every edge; tens advances on the ones carry.
    count100_bcd_digit_counter u_ones (
        .clk    (clk),
        .rst_n  (reset),
        .cin    (1'b1),
        .clr    (wrap_c),
        .digit  (count_ones),
        .cout_c (ones_cout_c)
    );

    count100_bcd_digit_counter u_tens (
        .clk    (clk),
        .rst_n  (reset),
        .cin    (ones_cout_c),
        .clr    (wrap_c),
        .digit  (count_tens),
        .cout_c (unused_tens_cout)
    );

    assign count = count_q;
    assign tc    = (count_q == LAST);

endmodule : count100

// File: tb/tb_count100.sv
// ---------------------------------------------------------------------------
// tb_count100
// Directed bench for count100 (default 100-state build) plus a 60-state build.
// ---------------------------------------------------------------------------
module tb_count100;

    logic       clk;
    logic       reset;
    logic [7:0] count;
    logic [3:0] count_tens;
    logic [3:0] count_ones;
    logic       tc;
    logic [5:0] count60;
    logic [3:0] tens60;
    logic [3:0] ones60;
    logic       tc60;

    int vectors;
    int miscompares;

    count100 dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .count_tens (count_tens),
        .count_ones (count_ones),
        .tc         (tc)
    );

    count100 #(.MODULUS(60), .WIDTH(6)) dut60 (
        .clk        (clk),
        .reset      (reset),
        .count      (count60),
        .count_tens (tens60),
        .count_ones (ones60),
        .tc         (tc60)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held low from time 0 (registers start unknown): zeros with no edge.
    task automatic test_reset();
        reset = 1'b0;
        #1;
        vectors++;
        if (count !== 8'd0 || count_tens !== 4'd0 || count_ones !== 4'd0 || tc !== 1'b0) begin
            $display("FAIL reset_immediate: got count=%0d tens=%0d ones=%0d tc=%b, want 0/0/0/0",
                     count, count_tens, count_ones, tc);
            miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (count !== 8'd0 || count_tens !== 4'd0 || count_ones !== 4'd0 || tc !== 1'b0) begin
                $display("FAIL reset_hold[%0d]: got count=%0d tens=%0d ones=%0d tc=%b, want 0/0/0/0",
                         i, count, count_tens, count_ones, tc);
                miscompares++;
            end
        end
    endtask

    // Release on a falling edge: first rising edge gives 1, tenth gives 10 (1/0).
    task automatic test_release();
        int exp_cnt [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        int exp_tens[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        int exp_ones[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (count !== 8'(exp_cnt[i]) || count_tens !== 4'(exp_tens[i]) ||
                count_ones !== 4'(exp_ones[i]) || tc !== 1'b0) begin
                $display("FAIL release[%0d]: got count=%0d tens=%0d ones=%0d tc=%b, want %0d/%0d/%0d/0",
                         i, count, count_tens, count_ones, tc, exp_cnt[i], exp_tens[i], exp_ones[i]);
                miscompares++;
            end
        end
    endtask

    // 120 edges after release: passes 99 (tc once), wraps to 0, ends at 20.
    task automatic test_wrap();
        int exp;
        int tc_seen;
        exp = 0;
        tc_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            #1;
            exp = (exp == 99) ? 0 : exp + 1;
            if (tc === 1'b1) tc_seen++;
            vectors++;
            if (count !== 8'(exp) || count_tens !== 4'(exp / 10) || count_ones !== 4'(exp % 10) ||
                tc !== (exp == 99) || int'(count) != 10 * int'(count_tens) + int'(count_ones)) begin
                $display("FAIL wrap[%0d]: got count=%0d tens=%0d ones=%0d tc=%b, want %0d/%0d/%0d/%0b",
                         i, count, count_tens, count_ones, tc, exp, exp / 10, exp % 10, exp == 99);
                miscompares++;
            end
        end
        vectors++;
        if (tc_seen != 1 || count !== 8'd20) begin
            $display("FAIL wrap_summary: tc cycles=%0d final count=%0d, want 1 and 20", tc_seen, count);
            miscompares++;
        end
    endtask

    // Reset asserted between edges at count 37: clears at once, holds, restarts.
    task automatic test_midreset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (37) @(posedge clk);
        #1;
        vectors++;
        if (count !== 8'd37 || count_tens !== 4'd3 || count_ones !== 4'd7) begin
            $display("FAIL mid_pre: got count=%0d tens=%0d ones=%0d, want 37/3/7",
                     count, count_tens, count_ones);
            miscompares++;
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (count !== 8'd0 || count_tens !== 4'd0 || count_ones !== 4'd0 || tc !== 1'b0) begin
            $display("FAIL mid_async: got count=%0d tens=%0d ones=%0d tc=%b, want 0/0/0/0",
                     count, count_tens, count_ones, tc);
            miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (count !== 8'd0 || count_tens !== 4'd0 || count_ones !== 4'd0) begin
                $display("FAIL mid_hold[%0d]: got count=%0d tens=%0d ones=%0d, want 0/0/0",
                         i, count, count_tens, count_ones);
                miscompares++;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (count !== 8'(i) || count_ones !== 4'(i) || count_tens !== 4'd0) begin
                $display("FAIL mid_restart[%0d]: got count=%0d tens=%0d ones=%0d, want %0d/0/%0d",
                         i, count, count_tens, count_ones, i, i);
                miscompares++;
            end
        end
    endtask

    // Upset registers (count 150, digits 12/13) recover to 0/0/0 on the next edge.
    task automatic test_recovery();
        @(negedge clk);
        force dut.count_q = 8'd150;
        force dut.u_ones.digit_q = 4'd12;
        force dut.u_tens.digit_q = 4'd13;
        #1;
        release dut.count_q;
        release dut.u_ones.digit_q;
        release dut.u_tens.digit_q;
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 8'd0 || count_tens !== 4'd0 || count_ones !== 4'd0 || tc !== 1'b0) begin
            $display("FAIL recovery: got count=%0d tens=%0d ones=%0d tc=%b, want 0/0/0/0",
                     count, count_tens, count_ones, tc);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 8'd1 || count_ones !== 4'd1 || count_tens !== 4'd0) begin
            $display("FAIL recovery_next: got count=%0d tens=%0d ones=%0d, want 1/0/1",
                     count, count_tens, count_ones);
            miscompares++;
        end
    endtask

    // 60-state build: 0..59 then 0, tc only at 59 with digits 5/9.
    task automatic test_mod60();
        int exp;
        int tc_seen;
        exp = 0;
        tc_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (count60 !== 6'd0 || tens60 !== 4'd0 || ones60 !== 4'd0 || tc60 !== 1'b0) begin
            $display("FAIL mod60_reset: got count=%0d tens=%0d ones=%0d tc=%b, want 0/0/0/0",
                     count60, tens60, ones60, tc60);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            @(posedge clk);
            #1;
            exp = (exp == 59) ? 0 : exp + 1;
            if (tc60 === 1'b1) tc_seen++;
            vectors++;
            if (count60 !== 6'(exp) || tens60 !== 4'(exp / 10) || ones60 !== 4'(exp % 10) ||
                tc60 !== (exp == 59)) begin
                $display("FAIL mod60[%0d]: got count=%0d tens=%0d ones=%0d tc=%b, want %0d/%0d/%0d/%0b",
                         i, count60, tens60, ones60, tc60, exp, exp / 10, exp % 10, exp == 59);
                miscompares++;
            end
            if (i == 59) begin
                vectors++;
                if (tens60 !== 4'd5 || ones60 !== 4'd9 || tc60 !== 1'b1) begin
                    $display("FAIL mod60_tc: got tens=%0d ones=%0d tc=%b, want 5/9/1",
                             tens60, ones60, tc60);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (tc_seen != 1 || count60 !== 6'd5) begin
            $display("FAIL mod60_summary: tc cycles=%0d final count=%0d, want 1 and 5", tc_seen, count60);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        test_reset();
        test_release();
        test_wrap();
        test_midreset();
        test_recovery();
        test_mod60();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_count100

// File: doc/count100.md
Name: count100

Overview:
- Free-running modulo-100 up-counter for the image-processing hardware path.
- Provides a binary count value, a BCD (tens/ones) view of the same value, and a terminal-count flag.
- Counts 0..99 and wraps to 0; intended as a frame/line or sequencing timebase.
- Single clock domain, no enable; it advances on every rising clock edge while out of reset.

Parameters:
- MODULUS, 100, number of states. Count range is 0..MODULUS-1. Legal range 2..100 so the BCD view fits two digits.
- WIDTH, 8, width of the binary count output. Must satisfy 2^WIDTH >= MODULUS.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- count  output  WIDTH  current binary count, 0..MODULUS-1
- count_tens  output  4  BCD tens digit of count, 0..9
- count_ones  output  4  BCD ones digit of count, 0..9
- tc  output  1  terminal count, high while count == MODULUS-1

Behaviour:
- Reset:
  - reset low immediately forces count=0, count_tens=0, count_ones=0. No clock edge is needed.
  - Outputs hold these values for as long as reset is low; clock edges during reset are ignored.
- Release: reset is released asynchronously. The first rising clk edge after release loads count=1.
- Increment: on each rising clk edge with reset high:
  - if count == MODULUS-1, then count <= 0;
  - otherwise count <= count+1.
  - Latency: exactly one increment per edge.
- BCD view:
  - count_tens and count_ones are registered alongside count, updated on the same edge, never combinationally derived via divide.
  - On increment: if ones==9, then ones <= 0 and tens <= tens+1; otherwise ones <= ones+1.
  - On wrap, both digits go to 0.
  - Invariant at all times out of reset: count == 10*count_tens + count_ones.
- tc:
  - Combinational decode, high exactly when count == MODULUS-1.
  - Forced low during reset, since count is 0.
- Wrap: with MODULUS=100, the sequence is ...,98,99,0,1,...
  - count never takes values 100..255.
  - The tc high phase lasts exactly one clock period per 100 cycles.
- Reset mid-count: any value is abandoned immediately and the count restarts from 0. There is no pending or partial state.
- Power-up before the first reset assertion: outputs are undefined (X in simulation). The system must apply reset before using the outputs. No initial values are written in RTL.
- Illegal-state recovery: if count is ever >= MODULUS (e.g. an SEU), the next edge loads 0. Digits are re-aligned the same way: any digit >9 loads 0.
- All registers use a single always block per register group, sensitive to posedge clk and negedge reset.

Decomposition:
- Shared package: the default MODULUS constant (100) and a BCD digit typedef (4-bit).
- One sub-module is natural: bcd_digit_counter, a 0..9 digit with carry-in/carry-out. Instantiate it twice (ones, tens).
  - The tens carry-out is unused.
  - The synchronous clear on wrap comes from the top-level tc.
- The binary counter and tc decode stay in the top level.

Test Plan:
- Reset hold: drive reset=0 for 5 cycles from an unknown state -> count=0, tens=0, ones=0, tc=0 throughout, with no waiting for a clock edge.
- Release timing: deassert reset on a falling clk edge -> first rising edge gives count=1 (ones=1); after 10 edges, count=10, tens=1, ones=0.
- Wrap: run 120 cycles after release -> count reaches 99 with tc=1 for exactly one cycle, then 0, then continues to 20 at cycle 120. The tens/ones invariant is checked on every cycle.
- Mid-count async reset: at count=37, assert reset between clock edges -> count=0 within the same half-period; hold 5 cycles at 0; release -> 1,2,3...
- Parameter sweep: MODULUS=60, WIDTH=6 -> sequence 0..59 then 0; tc high only at 59; BCD 5/9 at terminal count.
- Recovery: force count=150 via a bench force/release -> next edge gives count=0, digits 0/0.
